mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
// - Load/store controller between the ALU/register-file datapath and data_memory.
// - Accepts byte/halfword/word loads and stores on a valid/ready request port.
// - Drives data_memory's address/writeData/memWrite/memRead and returns aligned, extended load data.
// - Sub-word stores are read-modify-write (2 memory cycles); the core stalls on !req_ready.
// PARAMETERS
// - ADDR_WIDTH  32  byte-address width of req_addr.
// - DATA_WIDTH  32  data width. Fixed at 32; 4 byte lanes, little-endian.
// - MEM_AW      6   word-index width driven to data_memory (matches its memory_size).
// PORTS
// - clk        in   1           rising-edge clock
// - rst_n      in   1           synchronous active-low reset
// - req_valid  in   1           request present
// - req_ready  out  1           unit idle; request accepted on valid&ready at posedge
// - req_store  in   1           1 = store, 0 = load
// - req_size   in   2           00 byte, 01 half, 10 word, 11 illegal
// - req_uns    in   1           load zero-extend (1) / sign-extend (0)
// - req_addr   in   ADDR_WIDTH  byte address from ALU result
// - req_wdata  in   DATA_WIDTH  store data from regfile read port 2; low bits used for sub-word
// - resp_valid out  1           one-cycle pulse: request finished
// - resp_rdata out  DATA_WIDTH  extended load data; 0 for stores and errors
// - resp_err   out  1           misaligned or illegal size; qualified by resp_valid
// - mem_addr   out  MEM_AW      word index = req_addr[MEM_AW+1:2]
// - mem_wdata  out  DATA_WIDTH  to data_memory writeData
// - mem_rdata  in   DATA_WIDTH  from data_memory readData (combinational)
// - mem_write  out  1           to data_memory memWrite
// - mem_read   out  1           to data_memory memRead
// BEHAVIOUR
// - Reset: when rst_n=0 at posedge, state goes to IDLE and all registers clear.
//   - After reset: resp_valid=0, resp_rdata=0, resp_err=0, mem_write=0, mem_read=0, mem_addr=0, mem_wdata=0.
//   - req_ready = (state==IDLE), so it is 1 after reset.
// - Accepting a request: on req_valid & req_ready, capture addr, wdata, size, uns and store into registers.
// - mem_* outputs come only from state and registered fields, never from req_* inputs.
//   - This keeps the address stable while data_memory write-enable is high.
// - States: IDLE, LOAD, WR, RMW_RD, RMW_WR, RESP.
// - Transitions from IDLE on accept:
//   - error (size=11, half with addr[0]=1, or word with addr[1:0]!=0): RESP with err=1; no memory access.
//   - load: LOAD.
//   - word store: WR.
//   - byte or half store: RMW_RD.
// - LOAD: mem_read=1; register the extracted lane into resp_rdata; go to RESP.
//   - Byte lane = addr[1:0]; half lane = addr[1].
//   - Extend to 32 bits per req_uns.
// - WR: mem_write=1 and mem_wdata = wdata for exactly one cycle; go to RESP.
// - RMW_RD: mem_read=1; capture mem_rdata into merge register; go to RMW_WR.
// - RMW_WR: mem_write=1; mem_wdata = merge register with the target lane replaced; go to RESP.
//   - Target lane is addressed by addr[1:0] (byte) or addr[1] (half).
//   - Lane data comes from wdata[7:0] or wdata[15:0].
// - RESP: resp_valid=1 for one cycle; go to IDLE.
//   - resp_rdata and resp_err hold until the next accept.
// - Latency from accept edge to resp_valid:
//   - load: 2 cycles.
//   - word store: 2 cycles.
//   - sub-word store: 3 cycles.
//   - error: 1 cycle.
// - Throughput: the next request can be accepted in the cycle after RESP.
// - mem_read and mem_write are never both 1. Both are 0 in IDLE and RESP.
// - req_valid while busy is ignored; the requester holds its request until req_ready.
// - Reset mid-operation (any state): abort at that edge and return to IDLE.
//   - No mem_write after the reset edge.
//   - An aborted RMW leaves the memory word unchanged.
// - Upper address bits above MEM_AW+1 are ignored (wrap-around within memory).
// TESTING
// - Store word 0xDEADBEEF @0x10, then load word @0x10:
//   - mem_write high for 1 cycle at mem_addr=4.
//   - Load returns 0xDEADBEEF with resp_valid 2 cycles after accept.
// - Store byte 0x80 @0x11 (word previously 0xDEADBEEF):
//   - mem_wdata=0xDEAD80EF in RMW_WR; resp_valid 3 cycles after accept.
//   - Then load byte signed @0x11 gives 0xFFFFFF80; unsigned gives 0x00000080.
// - Store half 0x1234 @0x12, then load half signed @0x12:
//   - Word becomes 0x123480EF; load returns 0x00001234.
// - Misaligned cases: load word @0x13, store half @0x11, size=11:
//   - resp_err=1 one cycle after accept; mem_read and mem_write stay 0.
// - Assert rst_n=0 during RMW_RD of a byte store @0x10:
//   - No mem_write occurs; a subsequent word load returns the prior value.
//   - req_ready=1 after reset.
// - Back-to-back requests with req_valid held high:
//   - req_ready is low while busy; exactly one memory access sequence per accept.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store controller between the datapath and a combinational-read data_memory.
// Sub-word stores are performed as read-modify-write; mem_* outputs derive only from registered state.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_AW     = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic [1:0]            req_size,
    input  logic                  req_uns,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [MEM_AW-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_write,
    output logic                  mem_read
);

    localparam int AW = MEM_AW + 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WR,
        RMW_RD,
        RMW_WR,
        RESP
    } state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [DATA_WIDTH-1:0] merge_q, merge_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  req_bad;
    logic [7:0]            byte_v;
    logic [15:0]           half_v;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] merged;

    // Address bits above the memory index are deliberately dropped (wrap-around).
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[ADDR_WIDTH-1:AW];

    assign req_ready  = (state_q == IDLE);
    assign mem_addr   = addr_q[AW-1:2];
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    always_comb begin
        req_bad = 1'b0;
        case (req_size)
            2'b01:   req_bad = req_addr[0];
            2'b10:   req_bad = (req_addr[1:0] != 2'b00);
            2'b11:   req_bad = 1'b1;
            default: req_bad = 1'b0;
        endcase
    end

    always_comb begin
        byte_v    = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        half_v    = mem_rdata[{addr_q[1], 4'b0000} +: 16];
        load_data = mem_rdata;
        case (size_q)
            2'b00:   load_data = {{24{~uns_q & byte_v[7]}}, byte_v};
            2'b01:   load_data = {{16{~uns_q & half_v[15]}}, half_v};
            default: load_data = mem_rdata;
        endcase
    end

    always_comb begin
        merged = merge_q;
        if (size_q == 2'b00) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        uns_d      = uns_q;
        merge_d    = merge_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_wdata  = '0;
        resp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr[AW-1:0];
                    wdata_d = req_wdata;
                    size_d  = req_size;
                    uns_d   = req_uns;
                    rdata_d = '0;
                    err_d   = req_bad;
                    if (req_bad) begin
                        state_d = RESP;
                    end else if (!req_store) begin
                        state_d = LOAD;
                    end else if (req_size == 2'b10) begin
                        state_d = WR;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            LOAD: begin
                mem_read = 1'b1;
                rdata_d  = load_data;
                state_d  = RESP;
            end
            WR: begin
                mem_write = 1'b1;
                mem_wdata = wdata_q;
                state_d   = RESP;
            end
            RMW_RD: begin
                mem_read = 1'b1;
                merge_d  = mem_rdata;
                state_d  = RMW_WR;
            end
            RMW_WR: begin
                mem_write = 1'b1;
                mem_wdata = merged;
                state_d   = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            merge_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural 64-word data_memory.
// Expected values are hand-computed constants.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_uns;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_write;
    logic        mem_read;

    logic [31:0] mem [64];
    int total = 0;
    int bad = 0;
    int both_cnt = 0;

    mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_AW(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_size(req_size), .req_uns(req_uns), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_write(mem_write), .mem_read(mem_read)
    );

    always #5 clk = ~clk;

    initial for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    always @(negedge clk) if (mem_read && mem_write) both_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request and follow it to resp_valid, tallying memory activity.
    task automatic do_req(input string tag, input logic st, input logic [1:0] sz, input logic un,
                          input logic [31:0] a, input logic [31:0] wd, input int lat,
                          input logic e, input logic [31:0] rd, input int nrd, input int nwr,
                          input logic [31:0] wexp);
        int n, rcnt, wcnt;
        logic [31:0] wv;
        logic [5:0]  wa;
        n = 0; rcnt = 0; wcnt = 0; wv = '0; wa = '0;
        @(negedge clk);
        req_valid = 1'b1; req_store = st; req_size = sz; req_uns = un;
        req_addr = a; req_wdata = wd;
        check({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (mem_read) rcnt++;
            if (mem_write) begin wcnt++; wv = mem_wdata; wa = mem_addr; end
        end while (!resp_valid && n < 10);
        check({tag, "_lat"}, n, lat);
        check({tag, "_err"}, {31'b0, resp_err}, {31'b0, e});
        check({tag, "_rdata"}, resp_rdata, rd);
        check({tag, "_nrd"}, rcnt, nrd);
        check({tag, "_nwr"}, wcnt, nwr);
        if (nwr > 0) begin
            check({tag, "_wdata"}, wv, wexp);
            check({tag, "_waddr"}, {26'b0, wa}, {26'b0, a[7:2]});
        end
    endtask

    initial begin
        int acc, wr, rdc;
        rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00;
        req_uns = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", {31'b0, resp_err}, 32'd0);
        check("rst_mem_write", {31'b0, mem_write}, 32'd0);
        check("rst_mem_read", {31'b0, mem_read}, 32'd0);
        check("rst_mem_addr", {26'b0, mem_addr}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        rst_n = 1'b1;

        //      tag      st    sz     un    addr        wdata         lat err rdata         rd wr wexp
        do_req("sw10",   1'b1, 2'b10, 1'b0, 32'h10,  32'hDEADBEEF, 2, 1'b0, 32'h0,        0, 1, 32'hDEADBEEF);
        do_req("lw10",   1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        2, 1'b0, 32'hDEADBEEF, 1, 0, 32'h0);
        do_req("sb11",   1'b1, 2'b00, 1'b0, 32'h11,  32'hFFFFFF80, 3, 1'b0, 32'h0,        1, 1, 32'hDEAD80EF);
        do_req("lb11",   1'b0, 2'b00, 1'b0, 32'h11,  32'h0,        2, 1'b0, 32'hFFFFFF80, 1, 0, 32'h0);
        do_req("lbu11",  1'b0, 2'b00, 1'b1, 32'h11,  32'h0,        2, 1'b0, 32'h00000080, 1, 0, 32'h0);
        do_req("sh12",   1'b1, 2'b01, 1'b0, 32'h12,  32'hABCD1234, 3, 1'b0, 32'h0,        1, 1, 32'h123480EF);
        do_req("lh12",   1'b0, 2'b01, 1'b0, 32'h12,  32'h0,        2, 1'b0, 32'h00001234, 1, 0, 32'h0);
        do_req("lh10",   1'b0, 2'b01, 1'b0, 32'h10,  32'h0,        2, 1'b0, 32'hFFFF80EF, 1, 0, 32'h0);
        do_req("lhu10",  1'b0, 2'b01, 1'b1, 32'h10,  32'h0,        2, 1'b0, 32'h000080EF, 1, 0, 32'h0);
        do_req("lbu13",  1'b0, 2'b00, 1'b1, 32'h13,  32'h0,        2, 1'b0, 32'h00000012, 1, 0, 32'h0);
        do_req("lw_wrap",1'b0, 2'b10, 1'b0, 32'h110, 32'h0,        2, 1'b0, 32'h123480EF, 1, 0, 32'h0);
        do_req("lw13",   1'b0, 2'b10, 1'b0, 32'h13,  32'h0,        1, 1'b1, 32'h0,        0, 0, 32'h0);
        do_req("sh11",   1'b1, 2'b01, 1'b0, 32'h11,  32'h5555,     1, 1'b1, 32'h0,        0, 0, 32'h0);
        do_req("sz11",   1'b0, 2'b11, 1'b0, 32'h10,  32'h0,        1, 1'b1, 32'h0,        0, 0, 32'h0);

        // Reset while the RMW read is in progress.
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_size = 2'b00; req_uns = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h55;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("abort_in_rmw_rd", {31'b0, mem_read}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        wr = 0;
        @(negedge clk);
        check("abort_ready", {31'b0, req_ready}, 32'd1);
        if (mem_write) wr++;
        repeat (3) begin
            @(negedge clk);
            if (mem_write) wr++;
        end
        check("abort_no_write", wr, 32'd0);
        do_req("lw_after_abort", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 1'b0, 32'h123480EF, 1, 0, 32'h0);

        // Back-to-back word stores with req_valid held: one access per accept, period of 3 cycles.
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_size = 2'b10; req_uns = 1'b0;
        req_addr = 32'h20; req_wdata = 32'h11112222;
        acc = 0; wr = 0; rdc = 0;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            if (req_ready) acc++;
            if (mem_write) wr++;
            if (mem_read) rdc++;
            if (mem_write || mem_read) check("b2b_ready_low_busy", {31'b0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        check("b2b_accepts", acc, 32'd4);
        check("b2b_writes", wr, 32'd4);
        check("b2b_reads", rdc, 32'd0);
        repeat (2) @(negedge clk);
        check("b2b_mem", mem[8], 32'h11112222);
        check("rw_exclusive", both_cnt, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
